clock_alarm: RTL and testbench
==============================

Name: clock_alarm

Overview:
- Downstream consumer of the time-of-day counter outputs (hour, min, sec).
- Holds a programmable alarm time (hour:min) and raises `ring` when the running time reaches that hour:min at second 0.
- Supports auto-timeout of ringing, snooze with bounded repeat count, and manual stop.
- Sits between the time counter and the indicator/buzzer logic.

Parameters:
- HOUR_W, 3, width of hour input and alarm hour register
- MIN_W, 4, width of min input and alarm minute register
- SEC_W, 5, width of sec input
- RING_SECS, 8, number of second ticks ringing lasts before auto-stop (>=1)
- SNOOZE_SECS, 5, number of second ticks a snooze lasts (>=1)
- MAX_SNOOZE, 2, maximum snoozes per alarm event

Ports:
- clk  in  1  system clock, rising-edge
- rstn  in  1  asynchronous, active-high reset (asserted = 1, despite the name)
- hour  in  HOUR_W  current hour from time counter
- min  in  MIN_W  current minute from time counter
- sec  in  SEC_W  current second from time counter
- alarm_en  in  1  level; 1 = alarm enabled
- set_en  in  1  one-cycle strobe; load set_hour/set_min
- set_hour  in  HOUR_W  new alarm hour
- set_min  in  MIN_W  new alarm minute
- snooze  in  1  one-cycle strobe
- stop  in  1  one-cycle strobe
- ring  out  1  alarm sounding
- armed  out  1  state is ARMED, RINGING or SNOOZED
- alarm_hour  out  HOUR_W  stored alarm hour
- alarm_min  out  MIN_W  stored alarm minute
- snooze_cnt  out  2  snoozes used in current event (saturates at MAX_SNOOZE)

Behaviour:
- Reset (async, rstn=1): state=IDLE, ring=0, armed=0, alarm_hour=0, alarm_min=0, snooze_cnt=0, sec_q=0, ring_cnt=0, snz_timer=0.
- Second tick: sec_q registers sec every cycle; tick = (sec != sec_q), combinational.
- match = tick && sec==0 && hour==alarm_hour && min==alarm_min.
- FSM states:
  - IDLE: go to ARMED when alarm_en=1.
  - ARMED: on match, go to RINGING; ring_cnt=0.
  - RINGING:
    - on tick, ring_cnt++.
    - on the tick that makes ring_cnt==RING_SECS, go to ARMED and clear snooze_cnt.
    - on snooze with snooze_cnt<MAX_SNOOZE, go to SNOOZED; snz_timer=0; snooze_cnt++.
  - SNOOZED: on tick, snz_timer++; when snz_timer reaches SNOOZE_SECS, go to RINGING; ring_cnt=0.
- Priority, high to low, per cycle:
  1. rstn
  2. alarm_en=0: go to IDLE from any state; clear snooze_cnt, ring_cnt, snz_timer; alarm registers are kept.
  3. set_en: load alarm_hour/alarm_min; if alarm_en=1, state = ARMED (ringing or snooze cancelled, snooze_cnt=0).
  4. stop: in RINGING or SNOOZED, go to ARMED; snooze_cnt=0.
  5. snooze.
  6. timer/match transitions.
- set_en is honoured in IDLE: it loads the registers and the state stays IDLE.
- set_en and match in the same cycle: the new alarm is loaded and the match is ignored; no ring that cycle.
- Snooze when snooze_cnt==MAX_SNOOZE, or in any state other than RINGING: ignored, no state change.
- stop in IDLE/ARMED: ignored.
- Outputs are Moore, decoded from registered state:
  - ring = (state==RINGING).
  - armed = (state!=IDLE).
  - Latency: match in cycle N gives ring=1 from the clock edge ending cycle N.
- Stalled time counter (sec constant): no ticks, so the timers freeze and no re-match occurs.
- Re-match: the next match can only come after sec leaves 0 and returns to 0 at the same hour:min (i.e. the next wrap).
- Counter widths: ring_cnt >= clog2(RING_SECS+1), snz_timer >= clog2(SNOOZE_SECS+1); no wrap within an event.

Decomposition:
- Shared package clock_pkg:
  - HOUR_W, MIN_W, SEC_W constants, also used by the time counter.
  - alarm_state_t enum {IDLE, ARMED, RINGING, SNOOZED}.
- One natural sub-module, sec_tick_detect: sec_q register plus change compare producing tick. The rest lives in one FSM module.

Test Plan:
- Reset then idle: rstn=1 for 1 cycle, alarm_en=0, time runs -> ring=0, armed=0, alarm_hour=0, alarm_min=0 throughout.
- Basic alarm: set 1:2 with set_en, alarm_en=1; time reaches hour=1, min=2, sec=0 -> ring=1 on the next edge; held 8 ticks, then ring=0, armed=1.
- Snooze: ringing, snooze pulse -> ring=0, snooze_cnt=1; after 5 ticks ring=1. Repeat -> snooze_cnt=2; third snooze ignored, ring stays 1.
- Stop vs snooze same cycle while ringing -> ring=0, state ARMED, snooze_cnt=0.
- Mid-event control: alarm_en=0 while SNOOZED -> IDLE, armed=0. set_en coincident with match -> no ring; alarm registers show the new value.
- Async reset mid-ring: rstn pulsed between clock edges -> ring=0 and all outputs at reset values immediately, before the next edge.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared time-of-day widths and alarm state encoding.
// Used by the time counter and its downstream consumers.
// Pure declarations: no logic, no latency, no flow control.
package clock_pkg;

    // Widths of the time-of-day buses shared with the time counter
    localparam int HOUR_W = 3;
    localparam int MIN_W  = 4;
    localparam int SEC_W  = 5;

    // Width of the snooze-usage counter exposed on the alarm port
    localparam int SNZ_CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZED = 2'd3
    } alarm_state_t;

    // True while an alarm event is in progress (sounding or paused by snooze)
    function automatic logic event_active(input alarm_state_t st);
        return (st == RINGING) || (st == SNOOZED);
    endfunction

endpackage

// File: rtl/sec_tick_detect.sv
// Second-tick detector: flags any change of the incoming seconds value.
// Latency: tick is combinational against the previous-cycle seconds register.
// No backpressure: a stalled seconds bus simply produces no ticks.
module sec_tick_detect #(
    parameter int SEC_W = clock_pkg::SEC_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [SEC_W-1:0] sec,
    output logic             tick
);

    import clock_pkg::*;

    logic [SEC_W-1:0] sec_q;
    logic [SEC_W-1:0] sec_d;

    // Capture the seconds value every cycle
    always_comb begin
        sec_d = sec;
    end

    // Seconds history register (rstn is active-high despite its name)
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            sec_q <= '0;
        end else begin
            sec_q <= sec_d;
        end
    end

    // A tick is any cycle where the seconds value differs from last cycle
    always_comb begin
        tick = (sec != sec_q);
    end

endmodule

// File: rtl/clock_alarm.sv
// Alarm controller: rings at hour:min:00, with auto-timeout, bounded snooze and stop.
// Latency: a match seen in cycle N raises ring from the edge ending cycle N.
// No backpressure: strobes are sampled once; ignored strobes are simply dropped.
module clock_alarm #(
    parameter int HOUR_W      = clock_pkg::HOUR_W,
    parameter int MIN_W       = clock_pkg::MIN_W,
    parameter int SEC_W       = clock_pkg::SEC_W,
    parameter int RING_SECS   = 8,
    parameter int SNOOZE_SECS = 5,
    parameter int MAX_SNOOZE  = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [HOUR_W-1:0] hour,
    input  logic [MIN_W-1:0]  min,
    input  logic [SEC_W-1:0]  sec,
    input  logic              alarm_en,
    input  logic              set_en,
    input  logic [HOUR_W-1:0] set_hour,
    input  logic [MIN_W-1:0]  set_min,
    input  logic              snooze,
    input  logic              stop,
    output logic              ring,
    output logic              armed,
    output logic [HOUR_W-1:0] alarm_hour,
    output logic [MIN_W-1:0]  alarm_min,
    output logic [1:0]        snooze_cnt
);

    import clock_pkg::*;

    // Counters are sized so the terminal count is representable and never wraps
    localparam int RC_W = $clog2(RING_SECS + 1);
    localparam int SC_W = $clog2(SNOOZE_SECS + 1);

    localparam logic [RC_W-1:0] RING_END = RC_W'(RING_SECS);
    localparam logic [SC_W-1:0] SNZ_END  = SC_W'(SNOOZE_SECS);
    localparam logic [1:0]      SNZ_MAX  = 2'(MAX_SNOOZE);

    alarm_state_t      state_q,      state_d;
    logic [HOUR_W-1:0] alarm_hour_q, alarm_hour_d;
    logic [MIN_W-1:0]  alarm_min_q,  alarm_min_d;
    logic [1:0]        snooze_cnt_q, snooze_cnt_d;
    logic [RC_W-1:0]   ring_cnt_q,   ring_cnt_d;
    logic [SC_W-1:0]   snz_timer_q,  snz_timer_d;

    logic              tick;
    logic              match;
    logic [RC_W-1:0]   ring_cnt_inc;
    logic [SC_W-1:0]   snz_timer_inc;

    sec_tick_detect #(
        .SEC_W (SEC_W)
    ) u_tick (
        .clk  (clk),
        .rstn (rstn),
        .sec  (sec),
        .tick (tick)
    );

    // Alarm time reached: only on the tick that lands on second 0, so a
    // stalled counter sitting at :00 cannot re-trigger
    always_comb begin
        match         = tick && (sec == '0) &&
                        (hour == alarm_hour_q) && (min == alarm_min_q);
        ring_cnt_inc  = ring_cnt_q + 1'b1;
        snz_timer_inc = snz_timer_q + 1'b1;
    end

    // State and datapath registers (rstn is active-high despite its name)
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q      <= IDLE;
            alarm_hour_q <= '0;
            alarm_min_q  <= '0;
            snooze_cnt_q <= '0;
            ring_cnt_q   <= '0;
            snz_timer_q  <= '0;
        end else begin
            state_q      <= state_d;
            alarm_hour_q <= alarm_hour_d;
            alarm_min_q  <= alarm_min_d;
            snooze_cnt_q <= snooze_cnt_d;
            ring_cnt_q   <= ring_cnt_d;
            snz_timer_q  <= snz_timer_d;
        end
    end

    // Next state: disable > set > stop > snooze > timers/match
    always_comb begin
        state_d      = state_q;
        alarm_hour_d = alarm_hour_q;
        alarm_min_d  = alarm_min_q;
        snooze_cnt_d = snooze_cnt_q;
        ring_cnt_d   = ring_cnt_q;
        snz_timer_d  = snz_timer_q;

        // Programming the alarm time is honoured even while disabled
        if (set_en) begin
            alarm_hour_d = set_hour;
            alarm_min_d  = set_min;
        end

        if (!alarm_en) begin
            state_d      = IDLE;
            snooze_cnt_d = '0;
            ring_cnt_d   = '0;
            snz_timer_d  = '0;
        end else if (set_en) begin
            // New alarm time cancels any event in progress and masks a
            // coincident match against the old time
            state_d      = ARMED;
            snooze_cnt_d = '0;
            ring_cnt_d   = '0;
            snz_timer_d  = '0;
        end else if (stop && event_active(state_q)) begin
            state_d      = ARMED;
            snooze_cnt_d = '0;
        end else if (snooze && (state_q == RINGING) && (snooze_cnt_q < SNZ_MAX)) begin
            state_d      = SNOOZED;
            snz_timer_d  = '0;
            snooze_cnt_d = snooze_cnt_q + 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ARMED;
                end
                ARMED: begin
                    if (match) begin
                        state_d    = RINGING;
                        ring_cnt_d = '0;
                    end
                end
                RINGING: begin
                    if (tick) begin
                        ring_cnt_d = ring_cnt_inc;
                        // Auto-timeout ends the whole event, so snoozes reset
                        if (ring_cnt_inc == RING_END) begin
                            state_d      = ARMED;
                            snooze_cnt_d = '0;
                        end
                    end
                end
                SNOOZED: begin
                    if (tick) begin
                        snz_timer_d = snz_timer_inc;
                        if (snz_timer_inc == SNZ_END) begin
                            state_d    = RINGING;
                            ring_cnt_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from registered state
    always_comb begin
        ring       = (state_q == RINGING);
        armed      = (state_q != IDLE);
        alarm_hour = alarm_hour_q;
        alarm_min  = alarm_min_q;
        snooze_cnt = snooze_cnt_q;
    end

endmodule

// File: tb/tb_clock_alarm.sv
// Bench for clock_alarm: directed scenarios plus randomized traffic vs a reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// No backpressure: strobes are single-cycle pulses driven between edges.
module tb_clock_alarm;

    localparam int RING_SECS   = 8;
    localparam int SNOOZE_SECS = 5;
    localparam int MAX_SNOOZE  = 2;
    localparam int SEC_MOD     = 20;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic [2:0] hour = '0;
    logic [3:0] min = '0;
    logic [4:0] sec = '0;
    logic       alarm_en = 1'b0;
    logic       set_en = 1'b0;
    logic [2:0] set_hour = '0;
    logic [3:0] set_min = '0;
    logic       snooze = 1'b0;
    logic       stop = 1'b0;
    logic       ring;
    logic       armed;
    logic [2:0] alarm_hour;
    logic [3:0] alarm_min;
    logic [1:0] snooze_cnt;

    int total = 0;
    int bad = 0;

    clock_alarm #(
        .RING_SECS   (RING_SECS),
        .SNOOZE_SECS (SNOOZE_SECS),
        .MAX_SNOOZE  (MAX_SNOOZE)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .hour       (hour),
        .min        (min),
        .sec        (sec),
        .alarm_en   (alarm_en),
        .set_en     (set_en),
        .set_hour   (set_hour),
        .set_min    (set_min),
        .snooze     (snooze),
        .stop       (stop),
        .ring       (ring),
        .armed      (armed),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .snooze_cnt (snooze_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: alarm mode plus a count of seconds still to go
    localparam int M_OFF = 0, M_WAIT = 1, M_SOUND = 2, M_NAP = 3;
    int         m_mode;
    int         m_left;
    int         m_snz;
    logic [2:0] m_ah;
    logic [3:0] m_am;
    logic [4:0] m_prev_sec;

    task automatic model_reset();
        m_mode = M_OFF; m_left = 0; m_snz = 0;
        m_ah = '0; m_am = '0; m_prev_sec = '0;
    endtask

    task automatic model_edge();
        bit new_sec, hit;
        new_sec = (sec != m_prev_sec);
        hit = new_sec && (sec == 5'd0) && (hour == m_ah) && (min == m_am);
        if (set_en) begin m_ah = set_hour; m_am = set_min; end
        if (!alarm_en) begin
            m_mode = M_OFF; m_snz = 0;
        end else if (set_en) begin
            m_mode = M_WAIT; m_snz = 0;
        end else if (stop && (m_mode == M_SOUND || m_mode == M_NAP)) begin
            m_mode = M_WAIT; m_snz = 0;
        end else if (snooze && m_mode == M_SOUND && m_snz < MAX_SNOOZE) begin
            m_mode = M_NAP; m_left = SNOOZE_SECS; m_snz++;
        end else if (m_mode == M_OFF) begin
            m_mode = M_WAIT;
        end else if (m_mode == M_WAIT) begin
            if (hit) begin m_mode = M_SOUND; m_left = RING_SECS; end
        end else if (new_sec) begin
            m_left--;
            if (m_left == 0) begin
                if (m_mode == M_SOUND) begin m_mode = M_WAIT; m_snz = 0; end
                else begin m_mode = M_SOUND; m_left = RING_SECS; end
            end
        end
        m_prev_sec = sec;
    endtask

    // One clock: model consumes the inputs the DUT sees at this edge
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic bump_time();
        if (sec == 5'(SEC_MOD - 1)) begin
            sec = 5'd0;
            if (min == 4'd15) hour = hour + 3'd1;
            min = min + 4'd1;
        end else begin
            sec = sec + 5'd1;
        end
    endtask

    task automatic adv_time(input int hold);
        bump_time();
        for (int i = 0; i < hold; i++) cycle();
    endtask

    task automatic set_time(input logic [2:0] h, input logic [3:0] m, input logic [4:0] s);
        hour = h; min = m; sec = s;
        cycle();
    endtask

    task automatic load_alarm(input logic [2:0] h, input logic [3:0] m);
        set_en = 1'b1; set_hour = h; set_min = m;
        cycle();
        set_en = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({ring, armed, alarm_hour, alarm_min, snooze_cnt} !== 11'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0", {ring, armed, alarm_hour, alarm_min, snooze_cnt});
        end
        @(posedge clk); #1;
        rstn = 1'b0;
        model_reset();
        alarm_en = 1'b0;
        for (int i = 0; i < 30; i++) begin
            adv_time(1 + int'($urandom_range(0, 1)));
            total++;
            if ({ring, armed, alarm_hour, alarm_min} !== 9'd0) begin
                bad++;
                $display("FAIL idle_quiet: got %b want 0", {ring, armed, alarm_hour, alarm_min});
            end
        end
        load_alarm(3'd5, 4'd9);
        total++;
        if (alarm_hour !== 3'd5 || alarm_min !== 4'd9 || armed !== 1'b0) begin
            bad++;
            $display("FAIL idle_set: got %0d:%0d armed=%b want 5:9 armed=0", alarm_hour, alarm_min, armed);
        end
    endtask

    task automatic test_basic();
        set_time(3'd1, 4'd1, 5'd18);
        alarm_en = 1'b1;
        cycle();
        total++;
        if (armed !== 1'b1) begin bad++; $display("FAIL basic_armed: armed=%b want 1", armed); end
        load_alarm(3'd1, 4'd2);
        total++;
        if (alarm_hour !== 3'd1 || alarm_min !== 4'd2 || ring !== 1'b0) begin
            bad++;
            $display("FAIL basic_load: got %0d:%0d ring=%b want 1:2 ring=0", alarm_hour, alarm_min, ring);
        end
        adv_time(2);
        adv_time(1);
        total++;
        if (ring !== 1'b1) begin bad++; $display("FAIL basic_ring_latency: ring=%b want 1", ring); end
        for (int i = 0; i < 25; i++) cycle();
        total++;
        if (ring !== 1'b1) begin bad++; $display("FAIL basic_stall_hold: ring=%b want 1", ring); end
        for (int i = 0; i < RING_SECS - 1; i++) adv_time(2);
        total++;
        if (ring !== 1'b1) begin bad++; $display("FAIL basic_ring_last: ring=%b want 1", ring); end
        adv_time(1);
        total++;
        if (ring !== 1'b0 || armed !== 1'b1 || snooze_cnt !== 2'd0) begin
            bad++;
            $display("FAIL basic_timeout: ring=%b armed=%b snz=%0d want 0 1 0", ring, armed, snooze_cnt);
        end
    endtask

    task automatic test_snooze();
        load_alarm(3'd1, 4'd3);
        for (int i = 0; i < 11; i++) adv_time(1);
        total++;
        if (ring !== 1'b0) begin bad++; $display("FAIL snz_pre: ring=%b want 0", ring); end
        adv_time(1);
        total++;
        if (ring !== 1'b1) begin bad++; $display("FAIL snz_ring: ring=%b want 1", ring); end
        snooze = 1'b1; cycle(); snooze = 1'b0;
        total++;
        if (ring !== 1'b0 || snooze_cnt !== 2'd1 || armed !== 1'b1) begin
            bad++;
            $display("FAIL snz_first: ring=%b snz=%0d armed=%b want 0 1 1", ring, snooze_cnt, armed);
        end
        for (int i = 0; i < SNOOZE_SECS - 1; i++) adv_time(2);
        total++;
        if (ring !== 1'b0) begin bad++; $display("FAIL snz_wait: ring=%b want 0", ring); end
        adv_time(2);
        total++;
        if (ring !== 1'b1) begin bad++; $display("FAIL snz_wake1: ring=%b want 1", ring); end
        snooze = 1'b1; cycle(); snooze = 1'b0;
        total++;
        if (ring !== 1'b0 || snooze_cnt !== 2'd2) begin
            bad++;
            $display("FAIL snz_second: ring=%b snz=%0d want 0 2", ring, snooze_cnt);
        end
        for (int i = 0; i < SNOOZE_SECS; i++) adv_time(1);
        total++;
        if (ring !== 1'b1) begin bad++; $display("FAIL snz_wake2: ring=%b want 1", ring); end
        snooze = 1'b1; cycle(); snooze = 1'b0;
        total++;
        if (ring !== 1'b1 || snooze_cnt !== 2'd2) begin
            bad++;
            $display("FAIL snz_limit: ring=%b snz=%0d want 1 2", ring, snooze_cnt);
        end
        stop = 1'b1; snooze = 1'b1; cycle(); stop = 1'b0; snooze = 1'b0;
        total++;
        if (ring !== 1'b0 || armed !== 1'b1 || snooze_cnt !== 2'd0) begin
            bad++;
            $display("FAIL stop_vs_snooze: ring=%b armed=%b snz=%0d want 0 1 0", ring, armed, snooze_cnt);
        end
        for (int i = 0; i < 3; i++) adv_time(1);
        total++;
        if (ring !== 1'b0) begin bad++; $display("FAIL stop_stays: ring=%b want 0", ring); end
    endtask

    task automatic test_mid_event();
        load_alarm(3'd1, 4'd4);
        for (int i = 0; i < 7; i++) adv_time(1);
        total++;
        if (ring !== 1'b1) begin bad++; $display("FAIL mid_ring: ring=%b want 1", ring); end
        snooze = 1'b1; cycle(); snooze = 1'b0;
        adv_time(1);
        adv_time(1);
        alarm_en = 1'b0;
        cycle();
        total++;
        if (armed !== 1'b0 || ring !== 1'b0 || snooze_cnt !== 2'd0) begin
            bad++;
            $display("FAIL mid_disable: armed=%b ring=%b snz=%0d want 0 0 0", armed, ring, snooze_cnt);
        end
        total++;
        if (alarm_hour !== 3'd1 || alarm_min !== 4'd4) begin
            bad++;
            $display("FAIL mid_keep_regs: got %0d:%0d want 1:4", alarm_hour, alarm_min);
        end
        for (int i = 0; i < 3; i++) adv_time(1);
        total++;
        if (ring !== 1'b0 || armed !== 1'b0) begin
            bad++;
            $display("FAIL mid_idle_hold: ring=%b armed=%b want 0 0", ring, armed);
        end
        alarm_en = 1'b1;
        cycle();
        load_alarm(3'd1, 4'd5);
        while (sec != 5'(SEC_MOD - 1)) adv_time(1);
        set_en = 1'b1; set_hour = 3'd2; set_min = 4'd6;
        adv_time(1);
        set_en = 1'b0;
        total++;
        if (ring !== 1'b0 || armed !== 1'b1 || alarm_hour !== 3'd2 || alarm_min !== 4'd6) begin
            bad++;
            $display("FAIL set_vs_match: ring=%b armed=%b alarm=%0d:%0d want 0 1 2:6",
                     ring, armed, alarm_hour, alarm_min);
        end
        for (int i = 0; i < 3; i++) adv_time(1);
        total++;
        if (ring !== 1'b0) begin bad++; $display("FAIL set_vs_match_after: ring=%b want 0", ring); end
    endtask

    task automatic test_async_reset();
        load_alarm(3'd2, 4'd7);
        set_time(3'd2, 4'd6, 5'(SEC_MOD - 1));
        adv_time(1);
        total++;
        if (ring !== 1'b1) begin bad++; $display("FAIL arst_pre_ring: ring=%b want 1", ring); end
        #2;
        rstn = 1'b1;
        #1;
        total++;
        if ({ring, armed, alarm_hour, alarm_min, snooze_cnt} !== 11'd0) begin
            bad++;
            $display("FAIL arst_immediate: got %b want 0", {ring, armed, alarm_hour, alarm_min, snooze_cnt});
        end
        @(posedge clk); #1;
        rstn = 1'b0;
        model_reset();
        cycle();
        total++;
        if (armed !== 1'b1 || ring !== 1'b0) begin
            bad++;
            $display("FAIL arst_rearm: armed=%b ring=%b want 1 0", armed, ring);
        end
    endtask

    task automatic test_random();
        int r;
        alarm_en = 1'b1;
        load_alarm(3'd1, 4'd2);
        for (int n = 0; n < 3000; n++) begin
            set_en   = ($urandom_range(0, 59) == 0);
            set_hour = 3'($urandom_range(0, 1));
            set_min  = 4'($urandom_range(0, 3));
            snooze   = ($urandom_range(0, 7) == 0);
            stop     = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 79) == 0) alarm_en = 1'b0;
            else if (!alarm_en && $urandom_range(0, 9) == 0) alarm_en = 1'b1;
            r = int'($urandom_range(0, 39));
            if (r == 0) begin
                hour = (m_am == 4'd0) ? m_ah - 3'd1 : m_ah;
                min  = m_am - 4'd1;
                sec  = 5'(SEC_MOD - 1);
            end else if (r < 20) begin
                bump_time();
            end
            cycle();
            set_en = 1'b0; snooze = 1'b0; stop = 1'b0;
            total++;
            if (ring !== (m_mode == M_SOUND)) begin
                bad++; $display("FAIL rnd_ring n=%0d: got %b want %b", n, ring, m_mode == M_SOUND);
            end
            total++;
            if (armed !== (m_mode != M_OFF)) begin
                bad++; $display("FAIL rnd_armed n=%0d: got %b want %b", n, armed, m_mode != M_OFF);
            end
            total++;
            if (alarm_hour !== m_ah) begin
                bad++; $display("FAIL rnd_alarm_hour n=%0d: got %0d want %0d", n, alarm_hour, m_ah);
            end
            total++;
            if (alarm_min !== m_am) begin
                bad++; $display("FAIL rnd_alarm_min n=%0d: got %0d want %0d", n, alarm_min, m_am);
            end
            total++;
            if (snooze_cnt !== 2'(m_snz)) begin
                bad++; $display("FAIL rnd_snooze_cnt n=%0d: got %0d want %0d", n, snooze_cnt, m_snz);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_snooze();
        test_mid_event();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
